mmio_spi_controller: RTL and testbench

- Memory-mapped SPI master peripheral downstream of the MMU in rv32i_system. Drives the display's spi_clk, spi_mosi and display_csb, and samples spi_miso.
- The core moves bytes by storing and loading through the MMU. The MMU decodes the peripheral window and presents a 4-word register slice to this block.
- SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first, programmable clock divider.

---
 rtl/mmio_spi_controller.sv | 137 +++++++++++++
 tb/tb_mmio_spi_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mmio_spi_controller.sv
// Memory-mapped SPI master (mode 0, 8-bit, MSB first) behind a 4-word register slice.
// CTRL/STATUS, TXDATA, RXDATA, CLKDIV; one transfer in flight, extra TX writes flag overrun.
module mmio_spi_controller #(
  parameter int DEFAULT_DIV = 4,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        wr_ena,
  input  logic [31:0] wr_data,
  input  logic        rd_ena,
  output logic [31:0] rd_data,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_csb,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, n_lat, clkdiv, div_eff;
  logic [7:0]       shift, rx_byte;
  logic [3:0]       bit_cnt;
  logic             rx_valid, overrun, cs_hold, cs_hold_d;
  logic             clk_q, mosi_q, csb_q;
  logic             wr_ctrl, wr_tx, rd_rx, wr_div, tick;
  logic             start, enter_high, enter_low, done;

  wire unused = ^{addr[1:0], wr_data};

  assign wr_ctrl   = wr_ena && addr[3:2] == 2'd0;
  assign wr_tx     = wr_ena && addr[3:2] == 2'd1;
  assign rd_rx     = rd_ena && addr[3:2] == 2'd2;
  assign wr_div    = wr_ena && addr[3:2] == 2'd3;
  assign busy      = state != IDLE;
  assign tick      = cnt == n_lat - ONE;
  assign div_eff   = (clkdiv == '0) ? ONE : clkdiv;
  // Use the post-write cs_hold so a CTRL write acts on csb in the same edge.
  assign cs_hold_d = wr_ctrl ? wr_data[8] : cs_hold;

  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;
  assign spi_csb  = csb_q;

  always_comb begin
    state_d    = state;
    start      = 1'b0;
    enter_high = 1'b0;
    enter_low  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (wr_tx) begin start = 1'b1; state_d = SETUP; end
      SETUP: if (tick) begin enter_high = 1'b1; state_d = HIGH; end
      HIGH:  if (tick) begin enter_low = 1'b1; state_d = LOW; end
      LOW: begin
        if (tick) begin
          if (bit_cnt == 4'd8) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            enter_high = 1'b1;
            state_d    = HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n_lat    <= ONE;
      clkdiv   <= DIV_W'(DEFAULT_DIV);
      shift    <= '0;
      rx_byte  <= '0;
      bit_cnt  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      cs_hold  <= 1'b0;
      clk_q    <= 1'b0;
      mosi_q   <= 1'b0;
      csb_q    <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= (state == IDLE || tick) ? '0 : cnt + ONE;

      if (start) begin
        shift   <= wr_data[7:0];
        n_lat   <= div_eff;
        bit_cnt <= '0;
        mosi_q  <= wr_data[7];
        csb_q   <= 1'b0;
      end else if (state == IDLE && !cs_hold_d) begin
        csb_q <= 1'b1;
      end

      if (enter_high) begin
        clk_q   <= 1'b1;
        shift   <= {shift[6:0], spi_miso};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (enter_low) begin
        clk_q  <= 1'b0;
        mosi_q <= shift[7];
      end
      if (done) begin
        clk_q   <= 1'b0;
        mosi_q  <= 1'b0;
        rx_byte <= shift;
        csb_q   <= !cs_hold_d;
      end

      // Set beats clear for both sticky flags.
      rx_valid <= done || (rx_valid && !rd_rx);
      overrun  <= (wr_tx && busy) || (overrun && !(wr_ctrl && wr_data[2]));
      cs_hold  <= cs_hold_d;
      if (wr_div) clkdiv <= wr_data[DIV_W-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[3:2])
      2'd0: rd_data = {23'b0, cs_hold, 5'b0, overrun, rx_valid, busy};
      2'd1: rd_data = '0;
      2'd2: rd_data = {24'b0, rx_byte};
      2'd3: rd_data = 32'(clkdiv);
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_mmio_spi_controller.sv
// Directed bench for mmio_spi_controller: timing, loopback data, overrun, cs_hold, reset.
module tb_mmio_spi_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic        wr_ena = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ena = 1'b0;
  logic [31:0] rd_data;
  logic        spi_clk, spi_mosi, spi_miso, spi_csb, busy;
  logic        loop = 1'b1;
  logic        miso_val = 1'b0;

  int total = 0;
  int bad = 0;

  assign spi_miso = loop ? spi_mosi : miso_val;

  mmio_spi_controller #(.DEFAULT_DIV(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_ena(wr_ena), .wr_data(wr_data),
    .rd_ena(rd_ena), .rd_data(rd_data), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_csb(spi_csb), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_ena = 1'b1;
    @(negedge clk);
    wr_ena = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_ena = 1'b1;
    #1 d = rd_data;
    @(negedge clk);
    rd_ena = 1'b0;
  endtask

  // Start a transfer and watch it from the first busy cycle to the end.
  task automatic xfer(input logic [7:0] d, output int cyc, output int pulses,
                      output int hicyc, output logic [7:0] mbits, output int csb_hi);
    logic prev;
    cyc = 0; pulses = 0; hicyc = 0; mbits = '0; csb_hi = 0; prev = 1'b0;
    wr(4'h4, {24'b0, d});
    while (busy && cyc < 5000) begin
      cyc++;
      if (spi_clk && !prev) begin
        pulses++;
        mbits = {mbits[6:0], spi_mosi};
      end
      if (spi_clk) hicyc++;
      if (spi_csb) csb_hi++;
      prev = spi_clk;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    int cyc, pulses, hicyc, csb_hi, csb_hi2;
    logic [7:0] mb;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(4'h0, r); chk("rst_status", r, 32'h0);
    rd(4'hC, r); chk("rst_clkdiv", r, 32'h4);
    chk("rst_csb", {31'b0, spi_csb}, 32'h1);
    chk("rst_sclk", {31'b0, spi_clk}, 32'h0);

    // N=1 loopback
    wr(4'hC, 32'd1);
    loop = 1'b1;
    xfer(8'hA5, cyc, pulses, hicyc, mb, csb_hi);
    chk("n1_busy", cyc, 17);
    chk("n1_pulses", pulses, 8);
    chk("n1_hicyc", hicyc, 8);
    chk("n1_mosi", {24'b0, mb}, 32'hA5);
    chk("n1_csb_low", csb_hi, 0);
    chk("n1_csb_end", {31'b0, spi_csb}, 32'h1);
    rd(4'h0, r); chk("n1_status", r, 32'h2);
    rd(4'h8, r); chk("n1_rx", r, 32'hA5);
    rd(4'h0, r); chk("n1_status_clr", r, 32'h0);
    rd(4'h4, r); chk("tx_reads0", r, 32'h0);

    // N=3, miso high
    wr(4'hC, 32'd3);
    loop = 1'b0; miso_val = 1'b1;
    xfer(8'h00, cyc, pulses, hicyc, mb, csb_hi);
    chk("n3_busy", cyc, 51);
    chk("n3_hicyc", hicyc, 24);
    chk("n3_pulses", pulses, 8);
    chk("n3_mosi", {24'b0, mb}, 32'h00);
    rd(4'h8, r); chk("n3_rx", r, 32'hFF);

    // CLKDIV=0 behaves as 1
    wr(4'hC, 32'd0);
    rd(4'hC, r); chk("div0_read", r, 32'h0);
    loop = 1'b1;
    xfer(8'h3C, cyc, pulses, hicyc, mb, csb_hi);
    chk("div0_busy", cyc, 17);
    rd(4'h8, r); chk("div0_rx", r, 32'h3C);

    // Overrun during a transfer
    wr(4'hC, 32'd2);
    wr(4'h4, 32'h5A);
    repeat (3) @(negedge clk);
    wr(4'h4, 32'h3C);
    rd(4'h0, r); chk("ovr_status_busy", r, 32'h5);
    wait_idle();
    rd(4'h0, r); chk("ovr_status_done", r, 32'h6);
    wr(4'h0, 32'h4);
    rd(4'h0, r); chk("ovr_cleared", r, 32'h2);
    rd(4'h8, r); chk("ovr_rx", r, 32'h5A);

    // cs_hold across two transfers
    wr(4'hC, 32'd1);
    wr(4'h0, 32'h100);
    rd(4'h0, r); chk("hold_status", r, 32'h100);
    xfer(8'h12, cyc, pulses, hicyc, mb, csb_hi);
    repeat (2) @(negedge clk);
    chk("hold_csb_gap", {31'b0, spi_csb}, 32'h0);
    xfer(8'h34, cyc, pulses, hicyc, mb, csb_hi2);
    chk("hold_csb_xfer", csb_hi + csb_hi2, 0);
    chk("hold_csb_after", {31'b0, spi_csb}, 32'h0);
    rd(4'h8, r); chk("hold_rx", r, 32'h34);
    wr(4'h0, 32'h0);
    chk("hold_release", {31'b0, spi_csb}, 32'h1);

    // Reset mid-transfer
    wr(4'hC, 32'd2);
    wr(4'h4, 32'h77);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_csb", {31'b0, spi_csb}, 32'h1);
    chk("mrst_sclk", {31'b0, spi_clk}, 32'h0);
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    rd(4'h0, r); chk("mrst_status", r, 32'h0);
    rd(4'hC, r); chk("mrst_clkdiv", r, 32'h4);
    rd(4'h8, r); chk("mrst_rx", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
